// File: rtl/gate_test_sequencer_if.sv
// Bundle between the quad-AND test sequencer and its host/fixture: start request,
// gate stimulus/response and pass/fail result with first-failure capture.
interface gate_test_sequencer_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Y;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic [1:0] err_gate;
  logic [1:0] err_vec;
  logic [3:0] err_y;

  modport master (
    output start, Y,
    input  A, B, busy, done, pass, fail, err_gate, err_vec, err_y
  );

  modport slave (
    input  start, Y,
    output A, B, busy, done, pass, fail, err_gate, err_vec, err_y
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Walks a quad 2-input AND through four stimulus vectors, waits for the outputs
// to settle, and reports pass or the first failing gate/vector/response.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  gate_test_sequencer_if.slave bus
);
  localparam int unsigned S  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(S - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  // Gate g sees combination (v+g) mod 4, so neighbours always differ.
  function automatic logic [7:0] vec_pattern(input logic [1:0] v);
    logic [3:0] a, b;
    logic [1:0] c;
    for (int g = 0; g < 4; g++) begin
      c    = v + 2'(g);
      a[g] = c[1];
      b[g] = c[0];
    end
    return {a, b};
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic          pass_q, pass_d, fail_q, fail_d;
  logic [1:0]    err_gate_q, err_gate_d, err_vec_q, err_vec_d;
  logic [3:0]    err_y_q, err_y_d;
  logic [3:0]    mism;
  logic [1:0]    first_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_gate_q <= '0;
      err_vec_q  <= '0;
      err_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_gate_q <= err_gate_d;
      err_vec_q  <= err_vec_d;
      err_y_q    <= err_y_d;
    end
  end

  always_comb begin
    mism      = bus.Y ^ (a_q & b_q);
    first_bad = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mism[i]) first_bad = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_gate_d = err_gate_q;
    err_vec_d  = err_vec_q;
    err_y_d    = err_y_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          vec_d      = '0;
          {a_d, b_d} = vec_pattern(2'd0);
          cnt_d      = CNT_RELOAD;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          err_gate_d = '0;
          err_vec_d  = '0;
          err_y_d    = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CHECK: begin
        if (|mism) begin
          fail_d     = 1'b1;
          err_gate_d = first_bad;
          err_vec_d  = vec_q;
          err_y_d    = bus.Y;
          state_d    = DONE;
        end else if (vec_q == 2'd3) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else begin
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_pattern(vec_q + 2'd1);
          cnt_d      = CNT_RELOAD;
          state_d    = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.busy     = (state_q == SETTLE) || (state_q == CHECK);
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.done     = pass_q | fail_q;
  assign bus.err_gate = err_gate_q;
  assign bus.err_vec  = err_vec_q;
  assign bus.err_y    = err_y_q;
endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3, giving the clocks the driven inputs are held before Y is sampled; a value of 0 SHALL be treated as 1.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to run one test pass; sampled each clock.
REQ-005 SHALL have port A  output  4  gate A inputs, bit g drives gate g+1 (A1..A4).
REQ-006 SHALL have port B  output  4  gate B inputs, bit g drives gate g+1 (B1..B4).
REQ-007 SHALL have port Y  input  4  gate outputs, bit g from Yg+1 (quad 2-input AND under test).
REQ-008 SHALL have port busy  output  1  high while a pass is in progress.
REQ-009 SHALL have port done  output  1  high (level) once a pass has finished, until the next start or reset.
REQ-010 SHALL have port pass  output  1  high with done when all vectors matched.
REQ-011 SHALL have port fail  output  1  high with done when a mismatch was found.
REQ-012 SHALL have ports err_gate (output, 2), err_vec (output, 2) and err_y (output, 4), which capture the first failing gate index, the vector index and the sampled Y.

Function
REQ-013 SHALL implement the states IDLE, SETTLE, CHECK and DONE.
REQ-014 SHALL use vector v (0..3), which applies to gate g the combination c=(v+g) mod 4, with A[g]=c[1] and B[g]=c[0]; every gate therefore sees all four combinations with differing neighbours.
REQ-015 SHALL use these resulting patterns (A/B/expected Y, bit3..0): v0 1100/1010/1000; v1 0110/0101/0100; v2 0011/1010/0010; v3 1001/0101/0001.
REQ-016 SHALL, when in IDLE or DONE with start=1 at an edge, do the following at that edge: vec<=0, load A/B for v0, counter<=S-1 (S = effective SETTLE_CYCLES), clear done/pass/fail/err_*, enter SETTLE, busy<=1.
REQ-017 SHALL, in SETTLE, decrement the counter each edge, and enter CHECK at the edge where the counter equals 0; A/B SHALL be held stable.
REQ-018 SHALL, in CHECK, compare Y to A&B on all four bits at the next edge.
REQ-019 SHALL, on a CHECK mismatch, set fail=1, done=1 and busy=0, set err_gate to the lowest mismatching bit index, err_vec=vec and err_y=Y, and enter DONE; remaining vectors SHALL be skipped.
REQ-020 SHALL, on a CHECK match with vec<3, increment vec, load the next A/B, reload the counter to S-1 and enter SETTLE.
REQ-021 SHALL, on a CHECK match with vec=3, set pass=1, done=1 and busy=0, and enter DONE.
REQ-022 SHALL hold A/B at their last values in DONE, and drive A=B=0 in IDLE.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL have a latency such that, for a full passing run, done rises at edge 4*(S+1) counted from the edge that samples start (edge 0); for S=3 this is edge 16.
REQ-025 SHALL never have pass and fail high together, and SHALL have done equal to pass|fail.

Reset
REQ-026 SHALL, with reset=1 at an edge, force IDLE, A=B=0, busy=done=pass=fail=0, err_gate=err_vec=0, err_y=0, vec=0 and counter=0, regardless of state.
REQ-027 SHALL give reset priority over start at the same edge.
REQ-028 SHALL abort a run in progress when reset is asserted mid-run, with no done/pass/fail produced.

Verification
REQ-029 SHALL verify: reset held 2 clocks -> all outputs 0, A=B=0000.
REQ-030 SHALL verify: fault-free AND model, S=3, start pulsed 1 clock -> A/B steps through v0..v3 each held 4 clocks, busy high edges 0..15, done=pass=1 at edge 16, fail=0.
REQ-031 SHALL verify: model with Y[2] stuck-at-0 -> v0 passes, fail=1 at edge 8, err_gate=2, err_vec=1, err_y=0000, A/B held at 0110/0101.
REQ-032 SHALL verify: model with Y[0] stuck-at-1 -> fail=1 at edge 4, err_gate=0, err_vec=0, err_y=1001.
REQ-033 SHALL verify: start re-pulsed during SETTLE of v1 -> ignored, run completes at edge 16; then reset asserted during SETTLE of v2 on a new run -> next cycle IDLE, A=B=0, done stays 0.
REQ-034 SHALL verify: from DONE with fail=1, start pulsed with the fault removed -> fail/err_* clear at that edge, pass=1 after 16 edges; SETTLE_CYCLES=0 build -> behaves as S=1, done at edge 8.
